// File: rtl/ads_serial_capture.sv
// ADS serial capture: reads the ADC serial port after each ready strobe and packs sample pairs into 32-bit words.
// Optional build macro ADS_TEST_PATTERN_EN replaces ADC data with a {frame, word} index pattern when test_mode=1.
module ads_serial_capture #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int CH_NUM      = 8,
  parameter int FRAME_WORDS = 80
) (
  input  logic        clk_ps,
  input  logic        rst,
  input  logic        enable,
  input  logic        test_mode,
  input  logic        adc_drdy_n,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        data_valid,
  output logic [31:0] data,
  output logic        frame_done,
  output logic        overrun
);

  localparam int HALVES = 2 * CH_NUM * SAMPLE_BITS;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW     = $clog2(HALVES);
  localparam int WW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HALVES - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [HW-1:0] hcnt_q;
  logic          cs_n_q, sclk_q, run_q, enable_q, overrun_q;
  logic          drdy_s1_q, drdy_s2_q, drdy_s3_q, start_q;
  logic [30:0]   shreg_q;
  logic [4:0]    wbit_q;
  logic [WW-1:0] word_cnt_q;
  logic          data_valid_q, frame_done_q;
  logic [31:0]   data_q;
  logic          rise;
  logic [31:0]   adc_word;

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign data_valid = data_valid_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  // Two-flop synchroniser plus edge register: start pulses 3 cycles after the falling edge.
  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      drdy_s1_q <= 1'b1;
      drdy_s2_q <= 1'b1;
      drdy_s3_q <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      drdy_s1_q <= adc_drdy_n;
      drdy_s2_q <= drdy_s1_q;
      drdy_s3_q <= drdy_s2_q;
      start_q   <= drdy_s3_q & ~drdy_s2_q;
    end
  end

  // Cycles in which registered SCLK goes 0->1; adc_dout is sampled here.
  assign rise = (div_q == DIV_LAST) &&
                ((state_q == CS_SETUP) ||
                 (state_q == SHIFT && hcnt_q != H_LAST && !sclk_q));

  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      hcnt_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      run_q     <= 1'b0;
      enable_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q)                overrun_q <= 1'b0;
      else if (start_q && state_q != IDLE)    overrun_q <= 1'b1;

      // run only drops on a frame boundary so frames always complete
      if (state_q == IDLE && enable)          run_q <= 1'b1;
      else if (!enable && word_cnt_q == '0)   run_q <= 1'b0;

      case (state_q)
        IDLE: begin
          div_q <= '0;
          if (start_q && run_q) begin
            cs_n_q  <= 1'b0;
            state_q <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else div_q <= div_q + 1'b1;
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (hcnt_q == H_LAST) state_q <= CS_HOLD;
            else begin
              hcnt_q <= hcnt_q + 1'b1;
              sclk_q <= ~sclk_q;
            end
          end else div_q <= div_q + 1'b1;
        end
        CS_HOLD: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            state_q <= GAP;
          end else div_q <= div_q + 1'b1;
        end
        GAP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            state_q <= IDLE;
          end else div_q <= div_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_word = {shreg_q, adc_dout};

`ifdef ADS_TEST_PATTERN_EN
  logic [15:0] frame_idx_q;
  logic [31:0] out_word;
  assign out_word = test_mode ? {frame_idx_q, 16'(word_cnt_q)} : adc_word;

  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst)                                               frame_idx_q <= '0;
    else if (enable && !enable_q)                          frame_idx_q <= '0;
    else if (rise && wbit_q == 5'd31 && word_cnt_q == W_LAST) frame_idx_q <= frame_idx_q + 1'b1;
  end
`else
  logic [31:0] out_word;
  logic        unused_test_mode;
  assign out_word         = adc_word;
  assign unused_test_mode = test_mode;
`endif

  // Even samples end up in [31:16] because the word is shifted MSB first.
  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      shreg_q      <= '0;
      wbit_q       <= '0;
      word_cnt_q   <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
    end else begin
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (state_q == IDLE) wbit_q <= '0;
      if (rise) begin
        shreg_q <= {shreg_q[29:0], adc_dout};
        wbit_q  <= wbit_q + 1'b1;
        if (wbit_q == 5'd31) begin
          data_valid_q <= 1'b1;
          data_q       <= out_word;
          frame_done_q <= (word_cnt_q == W_LAST);
          word_cnt_q   <= (word_cnt_q == W_LAST) ? '0 : word_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ads_serial_capture.sv
// Scoreboard bench for ads_serial_capture with a behavioural ADC returning channel n = base + n.
module tb_ads_serial_capture;
  localparam int FW = 80;
  localparam int SP = 1045;

  logic        clk_ps = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        test_mode = 1'b0;
  logic        adc_drdy_n = 1'b1;
  logic        adc_dout;
  logic        adc_cs_n, adc_sclk, data_valid, frame_done, overrun;
  logic [31:0] data;

  always #5 clk_ps = ~clk_ps;

  ads_serial_capture dut (
    .clk_ps(clk_ps), .rst(rst), .enable(enable), .test_mode(test_mode),
    .adc_drdy_n(adc_drdy_n), .adc_dout(adc_dout), .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk), .data_valid(data_valid), .data(data),
    .frame_done(frame_done), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ADC model: bit index restarts on CS fall, advances on each SCLK fall.
  logic [15:0] base = 16'h0000;
  logic [7:0]  bidx = 8'd0;
  logic        cs_p = 1'b1, sc_p = 1'b0;
  logic [15:0] cur_ch;
  assign cur_ch   = base + {12'b0, bidx[7:4]};
  assign adc_dout = cur_ch[~bidx[3:0]];

  always @(posedge clk_ps) begin
    cs_p <= adc_cs_n;
    sc_p <= adc_sclk;
    if (cs_p && !adc_cs_n)      bidx <= 8'd0;
    else if (sc_p && !adc_sclk) bidx <= bidx + 8'd1;
  end

  int cs_cnt = 0, cs_len = 0;
  always @(negedge clk_ps) begin
    if (!adc_cs_n) cs_cnt++;
    else begin
      if (cs_cnt != 0) cs_len = cs_cnt;
      cs_cnt = 0;
    end
  end

  logic [31:0] sbq[$];
  int beats = 0, fdones = 0, fw = 0;

  always @(negedge clk_ps) begin
    if (rst) begin
      beats = 0; fdones = 0; fw = 0;
    end else if (data_valid) begin
      chk("sb_nonempty", {31'b0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) chk("data", data, sbq.pop_front());
      chk("frame_done", {31'b0, frame_done}, {31'b0, fw == FW - 1});
      beats++;
      if (frame_done) fdones++;
      fw = (fw == FW - 1) ? 0 : fw + 1;
    end else if (frame_done) begin
      chk("fd_alone", {31'b0, frame_done}, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_ps);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(3); rst = 1'b0; cyc(2);
  endtask

  task automatic push_conv(input logic [15:0] b);
    for (int c = 0; c < 8; c += 2) sbq.push_back({b + 16'(c), b + 16'(c + 1)});
  endtask

  task automatic strobe();
    adc_drdy_n = 1'b0; cyc(8); adc_drdy_n = 1'b1;
  endtask

  task automatic conv(input logic [15:0] b, input bit accepted);
    base = b;
    if (accepted) push_conv(b);
    strobe();
    cyc(SP - 8);
  endtask

  initial begin
    // reset state
    cyc(3);
    chk("rst_cs_n", {31'b0, adc_cs_n}, 32'd1);
    chk("rst_sclk", {31'b0, adc_sclk}, 32'd0);
    chk("rst_dv", {31'b0, data_valid}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    chk("rst_ovr", {31'b0, overrun}, 32'd0);

    // single conversion, known channel values
    rst = 1'b0; enable = 1'b1; cyc(4);
    conv(16'h1000, 1'b1);
    chk("cs_low_len", cs_len, 32'd1032);
    chk("t1_beats", beats, 32'd4);
    chk("t1_drain", sbq.size(), 32'd0);

`ifndef ADS_TEST_PATTERN_EN
    // one full frame
    do_reset();
    for (int i = 0; i < 20; i++) conv(16'h2000 + 16'(i * 16), 1'b1);
    chk("t2_beats", beats, 32'd80);
    chk("t2_fdones", fdones, 32'd1);
    chk("t2_ovr", {31'b0, overrun}, 32'd0);
    chk("t2_drain", sbq.size(), 32'd0);
`endif

    // enable dropped mid-frame: frame completes, later strobes ignored
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 5) enable = 1'b0;
      conv(16'h3000 + 16'(i * 16), 1'b1);
    end
    for (int i = 0; i < 2; i++) conv(16'h3800, 1'b0);
    chk("t3_beats", beats, 32'd80);
    chk("t3_fdones", fdones, 32'd1);
    chk("t3_ovr", {31'b0, overrun}, 32'd0);
    chk("t3_drain", sbq.size(), 32'd0);

    // overlapping strobe sets overrun
    enable = 1'b1;
    do_reset();
    base = 16'h4000; push_conv(16'h4000);
    strobe(); cyc(492);
    strobe(); cyc(SP);
    chk("t4_ovr_set", {31'b0, overrun}, 32'd1);
    chk("t4_beats", beats, 32'd4);
    chk("t4_drain", sbq.size(), 32'd0);
    enable = 1'b0; cyc(3); enable = 1'b1; cyc(3);
    chk("t4_ovr_clr", {31'b0, overrun}, 32'd0);

    // reset at SCLK rising edge 100
    do_reset();
    base = 16'h5000;
    for (int c = 0; c < 6; c += 2) sbq.push_back({16'h5000 + 16'(c), 16'h5000 + 16'(c + 1)});
    strobe();
    begin
      int rises = 0;
      logic sp = 1'b0;
      for (int i = 0; i < 3000 && rises < 100; i++) begin
        @(negedge clk_ps);
        if (adc_sclk && !sp) rises++;
        sp = adc_sclk;
      end
      chk("t5_sclk_edge100", rises, 32'd100);
    end
    rst = 1'b1; cyc(1);
    chk("t5_cs_n", {31'b0, adc_cs_n}, 32'd1);
    chk("t5_sclk", {31'b0, adc_sclk}, 32'd0);
    chk("t5_dv", {31'b0, data_valid}, 32'd0);
    cyc(3); rst = 1'b0; cyc(SP);
    chk("t5_drain_pre", sbq.size(), 32'd0);
    conv(16'h6000, 1'b1);
    chk("t5_drain", sbq.size(), 32'd0);

`ifdef ADS_TEST_PATTERN_EN
    // two frames of index pattern
    do_reset();
    test_mode = 1'b1; enable = 1'b0; cyc(2); enable = 1'b1; cyc(2);
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) sbq.push_back({16'(i / 20), 16'((i % 20) * 4 + k)});
      strobe();
      cyc(SP - 8);
    end
    chk("t6_fdones", fdones, 32'd2);
    chk("t6_drain", sbq.size(), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
